k2red_sched: RTL

//  Shares one k2red_s reduction pipeline (fixed latency, 1 op/cycle) among NREQ requesters.
//  - Round-robin arbitration; one operand issued per cycle.
//  - Tags each issued operand with its requester id and returns results in issue order.
//  - Owns the reduction parameters (Q, k1, k2, m) and reloads them only after the pipeline drains.

---
 rtl/k2red_sched_pkg.sv | 15 +
 rtl/k2red_sched_arb.sv | 32 +++
 rtl/k2red_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/k2red_sched_pkg.sv
// Shared widths, default reduction-core latency and scheduler state type for k2red_sched.
package k2red_pkg;

  localparam int unsigned AW          = 128;
  localparam int unsigned QW          = 64;
  localparam int unsigned KW          = 7;
  localparam int unsigned RED_LAT_DEF = 7;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/k2red_sched_arb.sv
// rr_arbiter: round-robin one-hot grant among requesters, searching from rr+1 upwards.
module rr_arbiter
  import k2red_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(rr) + i) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/k2red_sched.sv
// k2red_sched: shares one fixed-latency k2red_s reduction core among NREQ requesters, in-order results.
// Optional perf counters (perf_ops, perf_stall, perf_clr) when K2RED_SCHED_PERF_EN is defined.
module k2red_sched
  import k2red_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned RED_LAT = RED_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_a,
  output logic [NREQ-1:0]    req_ready,
  input  logic               cfg_we,
  input  logic [QW-1:0]      cfg_q,
  input  logic [KW-1:0]      cfg_k1,
  input  logic [KW-1:0]      cfg_k2,
  input  logic [KW-1:0]      cfg_m,
  output logic               cfg_busy,
`ifdef K2RED_SCHED_PERF_EN
  output logic [31:0]        perf_ops,
  output logic [31:0]        perf_stall,
  input  logic               perf_clr,
`endif
  output logic               red_rst,
  output logic [AW-1:0]      red_a,
  output logic [QW-1:0]      red_q,
  output logic [KW-1:0]      red_k1,
  output logic [KW-1:0]      red_k2,
  output logic [KW-1:0]      red_m,
  input  logic [QW-1:0]      red_c2,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [QW-1:0]      rsp_c
);

  // Tag chain spans the red_a register, the core input sample and RED_LAT core stages,
  // so its last stage lines up with red_c2.
  localparam int unsigned TD = RED_LAT + 2;
  localparam int unsigned CW = $clog2(TD + 1);

  state_t          state, state_nx;
  logic [IDW-1:0]  rr, gnt_id;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0]   gnt_a;
  logic            xfer, retire;
  logic [TD-1:0]   tag_v;
  logic [IDW-1:0]  tag_id [TD];
  logic [CW-1:0]   inflight;
  logic [QW-1:0]   sh_q;
  logic [KW-1:0]   sh_k1, sh_k2, sh_m;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .rr     (rr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = (state == ST_RUN && rst) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);
  assign retire    = tag_v[TD-1];

  always_comb begin
    gnt_a = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (gnt[i]) gnt_a = req_a[i*AW +: AW];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN:   if (cfg_we) state_nx = ST_DRAIN;
      ST_DRAIN: if (inflight == '0) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_RUN;
      default:  state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) red_rst <= 1'b1;
    else      red_rst <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      rr       <= '0;
      red_a    <= '0;
      tag_v    <= '0;
      inflight <= '0;
      for (int unsigned i = 0; i < TD; i++) tag_id[i] <= '0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        rr    <= gnt_id;
        red_a <= gnt_a;
      end
      tag_v     <= {tag_v[TD-2:0], xfer};
      tag_id[0] <= gnt_id;
      for (int unsigned i = 1; i < TD; i++) tag_id[i] <= tag_id[i-1];
      if (xfer && !retire)      inflight <= inflight + 1'b1;
      else if (!xfer && retire) inflight <= inflight - 1'b1;
    end
  end

  // A write arriving in LOAD itself is applied directly: last write wins, no second drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_busy <= 1'b0;
      sh_q     <= '0;
      sh_k1    <= '0;
      sh_k2    <= '0;
      sh_m     <= '0;
      red_q    <= '0;
      red_k1   <= '0;
      red_k2   <= '0;
      red_m    <= '0;
    end else begin
      if (cfg_we) begin
        sh_q  <= cfg_q;
        sh_k1 <= cfg_k1;
        sh_k2 <= cfg_k2;
        sh_m  <= cfg_m;
      end
      if (state == ST_RUN && cfg_we) cfg_busy <= 1'b1;
      else if (state == ST_LOAD)     cfg_busy <= 1'b0;
      if (state == ST_LOAD) begin
        red_q  <= cfg_we ? cfg_q  : sh_q;
        red_k1 <= cfg_we ? cfg_k1 : sh_k1;
        red_k2 <= cfg_we ? cfg_k2 : sh_k2;
        red_m  <= cfg_we ? cfg_m  : sh_m;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
    end else begin
      rsp_valid <= retire;
      if (retire) begin
        rsp_id <= tag_id[TD-1];
        rsp_c  <= red_c2;
      end
    end
  end

`ifdef K2RED_SCHED_PERF_EN
  logic stall;
  assign stall = |(req_valid & ~req_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else if (perf_clr) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (xfer && perf_ops != '1)    perf_ops   <= perf_ops + 32'd1;
      if (stall && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
